// File: rtl/mem_pkg.sv
// Shared definitions for the synchronous data memory: FSM encoding and
// parameter limits.
package mem_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  localparam int unsigned MAX_LATENCY = 8;

endpackage

// File: rtl/mem_array_be.sv
// Single-port word array with per-byte write enables and a combinational
// read of the addressed word.
module mem_array_be #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 256
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [$clog2(DEPTH)-1:0]   addr,
  input  logic [DATA_W/8-1:0]        be,
  input  logic [DATA_W-1:0]          wdata,
  output logic [DATA_W-1:0]          rdata
);

  localparam int unsigned NB = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned b = 0; b < NB; b++) begin
        if (be[b]) begin
          mem[addr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/sync_data_memory.sv
// Serialised data memory with byte enables, configurable response latency,
// address checking and a registered read port.
module sync_data_memory
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                MemRead,
  input  logic                MemWrite,
  input  logic [31:0]         Address,
  input  logic [DATA_W-1:0]   WriteData,
  input  logic [DATA_W/8-1:0] ByteEn,
  output logic [DATA_W-1:0]   ReadData,
  output logic                Done,
  output logic                Busy,
  output logic                AddrError
);

  localparam int unsigned NB  = DATA_W / 8;
  localparam int unsigned OFS = $clog2(NB);
  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned CW  = $clog2(LATENCY + 1);
  localparam logic [31:0] ALIGN_MASK = 32'(NB - 1);

  generate
    if (DATA_W == 0 || (DATA_W % 8) != 0) begin : g_bad_data_w
      $fatal(1, "DATA_W must be a nonzero multiple of 8");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $fatal(1, "DEPTH must be a power of 2 and at least 2");
    end
    if (NB > 1 && (NB & (NB - 1)) != 0) begin : g_bad_bytes
      $fatal(1, "DATA_W/8 must be a power of 2");
    end
    if (LATENCY < 1 || LATENCY > MAX_LATENCY) begin : g_bad_latency
      $fatal(1, "LATENCY must be in 1..MAX_LATENCY");
    end
    if (OFS + AW > 32) begin : g_bad_span
      $fatal(1, "DEPTH*DATA_W/8 exceeds the 32-bit byte address space");
    end
  endgenerate

  state_t          state, state_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic            any_req, bad_req, accept, reject, finish;
  logic            misaligned, out_of_range;
  logic            pend_rd;
  logic [DATA_W-1:0] cap;
  logic [DATA_W-1:0] arr_rdata;
  logic [AW-1:0]   widx;

  assign widx         = Address[OFS +: AW];
  assign misaligned   = (Address & ALIGN_MASK) != '0;
  assign out_of_range = (Address >> (OFS + AW)) != '0;
  assign any_req      = MemRead | MemWrite;
  assign bad_req      = misaligned | out_of_range | (MemRead & MemWrite);
  assign accept       = ~reset & (state == IDLE) & any_req & ~bad_req;
  assign reject       = (state == IDLE) & any_req & bad_req;
  assign finish       = (state == WAIT) & (cnt == '0);
  assign Busy         = (state == WAIT);

  mem_array_be #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk   (clk),
    .we    (accept & MemWrite),
    .addr  (widx),
    .be    (ByteEn),
    .wdata (WriteData),
    .rdata (arr_rdata)
  );

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nx = WAIT;
          cnt_nx   = CW'(LATENCY - 1);
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // The captured word is only forwarded if the pending request was a read,
  // so writes never disturb ReadData.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      ReadData  <= '0;
      Done      <= 1'b0;
      AddrError <= 1'b0;
      pend_rd   <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      Done      <= finish;
      AddrError <= reject;
      if (accept) begin
        pend_rd <= MemRead;
        cap     <= arr_rdata;
      end
      if (finish && pend_rd) begin
        ReadData <= cap;
      end
    end
  end

endmodule
